// File: rtl/mc_pic_if.sv
// Bus bundle between the interrupt controller and the cores and sources.
// The "slave" modport is the controller side; dbg_* expose per-core FSM state and ISR.
interface mc_pic_if #(
    parameter int NSRC  = 32,
    parameter int NCORE = 4,
    parameter int PW    = 2
);
    localparam int IW = $clog2(NSRC);

    logic [NSRC-1:0]     irq;
    logic [NSRC-1:0]     imr;
    logic [NSRC*PW-1:0]  prio_cfg;
    logic [NCORE-1:0]    int_req;
    logic [NCORE-1:0]    int_ack;
    logic [NCORE-1:0]    eoi;
    logic [NCORE*IW-1:0] int_id;
    logic [NCORE*32-1:0] vector;
    logic [NCORE-1:0]    vec_valid;
    logic [NCORE*2-1:0]  dbg_state;
    logic [NSRC-1:0]     dbg_isr;

    // Core k handshake: int_req[k] is high exactly while core k holds an
    // unacknowledged request; int_ack[k] is honoured only then. vec_valid[k]
    // is high exactly while in service; eoi[k] is honoured only then.
    modport master (
        output irq, imr, prio_cfg, int_ack, eoi,
        input  int_req, int_id, vector, vec_valid, dbg_state, dbg_isr
    );

    modport slave (
        input  irq, imr, prio_cfg, int_ack, eoi,
        output int_req, int_id, vector, vec_valid, dbg_state, dbg_isr
    );
endinterface

// File: rtl/mc_pic.sv
// Multi-core programmable interrupt controller: priority dispatch to the lowest idle core.
// Optional macro MC_PIC_RR_EN: round-robin tie-break among equal-highest priorities.
module mc_pic #(
    parameter int          NSRC  = 32,
    parameter int          NCORE = 4,
    parameter int          PW    = 2,
    parameter logic [31:0] VBASE = 32'hFFFF_FF00,
    localparam int         IW    = $clog2(NSRC)
) (
    input logic       clk,
    input logic       reset,
    mc_pic_if.slave   pic
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } core_state_e;

    core_state_e       state_q [NCORE];
    core_state_e       state_d [NCORE];
    logic [IW-1:0]     int_id_q [NCORE];
    logic [31:0]       vector_q [NCORE];
    logic [NSRC-1:0]   irr_q, irr_d;
    logic [NSRC-1:0]   isr_q, isr_d;
    logic [NSRC-1:0]   elig;
    logic [NSRC-1:0]   clr;
    logic              win_found;
    logic [IW-1:0]     win_id;
    logic [PW-1:0]     win_prio;
    logic              free_found;
    logic [NCORE-1:0]  disp_oh;
    logic              dispatch;

`ifdef MC_PIC_RR_EN
    logic [IW-1:0]     rr_q;
`endif

    // Winner search: strictly-greater replaces, so the first id visited wins a tie.
    always_comb begin
        elig      = irr_q & pic.imr & ~isr_q;
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        for (int j = 0; j < NSRC; j++) begin
            int idx;
`ifdef MC_PIC_RR_EN
            idx = int'(rr_q) + 1 + j;
            if (idx >= NSRC) idx = idx - NSRC;
`else
            idx = j;
`endif
            if (elig[idx] && (!win_found || (pic.prio_cfg[PW*idx +: PW] > win_prio))) begin
                win_found = 1'b1;
                win_id    = idx[IW-1:0];
                win_prio  = pic.prio_cfg[PW*idx +: PW];
            end
        end
    end

    always_comb begin
        disp_oh    = '0;
        free_found = 1'b0;
        for (int k = 0; k < NCORE; k++) begin
            if (!free_found && (state_q[k] == IDLE)) begin
                free_found = 1'b1;
                disp_oh[k] = win_found;
            end
        end
        dispatch = win_found & free_found;
    end

    always_comb begin
        clr = '0;
        if (dispatch) clr[win_id] = 1'b1;
        irr_d = (irr_q & ~clr) | pic.irq;

        isr_d = isr_q;
        for (int k = 0; k < NCORE; k++) begin
            if ((state_q[k] == SERV) && pic.eoi[k]) isr_d[int_id_q[k]] = 1'b0;
        end
        // A dispatched source has isr clear, so it never collides with an eoi clear.
        if (dispatch) isr_d[win_id] = 1'b1;
    end

    // Per-core FSM next state; ack wins over a simultaneous eoi in REQ.
    always_comb begin
        for (int k = 0; k < NCORE; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                IDLE:    if (disp_oh[k])     state_d[k] = REQ;
                REQ:     if (pic.int_ack[k]) state_d[k] = SERV;
                SERV:    if (pic.eoi[k])     state_d[k] = IDLE;
                default:                     state_d[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irr_q <= '0;
            isr_q <= '0;
            for (int k = 0; k < NCORE; k++) begin
                state_q[k]  <= IDLE;
                int_id_q[k] <= '0;
                vector_q[k] <= VBASE;
            end
        end else begin
            irr_q <= irr_d;
            isr_q <= isr_d;
            for (int k = 0; k < NCORE; k++) begin
                state_q[k] <= state_d[k];
                if (disp_oh[k]) int_id_q[k] <= win_id;
                if ((state_q[k] == REQ) && pic.int_ack[k]) vector_q[k] <= VBASE + 32'(int_id_q[k]);
            end
        end
    end

`ifdef MC_PIC_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         rr_q <= '0;
        else if (dispatch) rr_q <= win_id;
    end
`endif

    for (genvar k = 0; k < NCORE; k++) begin : g_out
        assign pic.int_req[k]          = (state_q[k] == REQ);
        assign pic.vec_valid[k]        = (state_q[k] == SERV);
        assign pic.int_id[IW*k +: IW]  = int_id_q[k];
        assign pic.vector[32*k +: 32]  = vector_q[k];
        assign pic.dbg_state[2*k +: 2] = state_q[k];
    end

    assign pic.dbg_isr = isr_q;

endmodule

// File: tb/tb_mc_pic.sv
// Self-checking bench for mc_pic: per-scenario tasks plus a dispatch scoreboard.
// Expected tie-break order follows MC_PIC_RR_EN when defined.
module tb_mc_pic;
    localparam int          NSRC  = 32;
    localparam int          NCORE = 4;
    localparam int          PW    = 2;
    localparam int          IW    = 5;
    localparam logic [31:0] VBASE = 32'hFFFF_FF00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [15:0] exp_q[$];
    logic [NCORE-1:0] req_prev = '0;

    always #5 clk = ~clk;

    mc_pic_if #(.NSRC(NSRC), .NCORE(NCORE), .PW(PW)) bus ();
    mc_pic #(.NSRC(NSRC), .NCORE(NCORE), .PW(PW), .VBASE(VBASE)) dut (
        .clk   (clk),
        .reset (reset),
        .pic   (bus)
    );

    // Scoreboard: each new int_req rise must match the next expected {core, id}.
    always @(negedge clk) begin
        if (reset) begin
            req_prev = '0;
        end else begin
            for (int k = 0; k < NCORE; k++) begin
                if (bus.int_req[k] && !req_prev[k]) begin
                    logic [15:0] got;
                    logic [15:0] e;
                    got = {8'(k), 8'(bus.int_id[IW*k +: IW])};
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL dispatch_unexpected: got core/id %h, required none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            tests_failed++;
                            $display("FAIL dispatch_order: got core/id %h, required %h", got, e);
                        end
                    end
                end
            end
            req_prev = bus.int_req;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.irq      = '0;
        bus.int_ack  = '0;
        bus.eoi      = '0;
        bus.imr      = '1;
        bus.prio_cfg = '0;
        cyc(2);
        reset = 1'b0;
        exp_q.delete();
        cyc(1);
    endtask

    task automatic pulse_irq(input logic [NSRC-1:0] m);
        bus.irq = m;
        cyc(1);
        bus.irq = '0;
    endtask

    task automatic ack_core(input int k);
        bus.int_ack[k] = 1'b1;
        cyc(1);
        bus.int_ack[k] = 1'b0;
    endtask

    task automatic eoi_core(input int k);
        bus.eoi[k] = 1'b1;
        cyc(1);
        bus.eoi[k] = 1'b0;
    endtask

    task automatic check_sb_empty(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_sb_leftover: %0d dispatches outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.irq = '0; bus.int_ack = '0; bus.eoi = '0; bus.imr = '1; bus.prio_cfg = '0;
        cyc(2);
        tests_run++;
        if ({bus.int_req, bus.vec_valid} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req/valid %h, required 0", {bus.int_req, bus.vec_valid});
        end
        tests_run++;
        if (bus.int_id !== '0 || bus.dbg_isr !== '0 || bus.dbg_state !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: id %h isr %h st %h, required 0", bus.int_id, bus.dbg_isr, bus.dbg_state);
        end
        for (int k = 0; k < NCORE; k++) begin
            tests_run++;
            if (bus.vector[32*k +: 32] !== VBASE) begin
                tests_failed++;
                $display("FAIL reset_vector%0d: got %h, required %h", k, bus.vector[32*k +: 32], VBASE);
            end
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back({8'd0, 8'd5});
        pulse_irq(32'h1 << 5);
        tests_run++;
        if (bus.int_req !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_early_req: got %b, required 0000", bus.int_req);
        end
        cyc(1);
        tests_run++;
        if (bus.int_req !== 4'b0001 || bus.int_id[0 +: IW] !== 5'd5) begin
            tests_failed++;
            $display("FAIL single_req: req %b id %0d, required 0001 id 5", bus.int_req, bus.int_id[0 +: IW]);
        end
        ack_core(0);
        tests_run++;
        if (bus.vec_valid !== 4'b0001 || bus.vector[0 +: 32] !== 32'hFFFF_FF05 || bus.int_req !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_serv: valid %b vec %h req %b, required 0001 FFFFFF05 0000",
                     bus.vec_valid, bus.vector[0 +: 32], bus.int_req);
        end
        tests_run++;
        if (bus.dbg_isr[5] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_isr_set: got %b, required 1", bus.dbg_isr[5]);
        end
        eoi_core(0);
        tests_run++;
        if (bus.vec_valid !== 4'b0000 || bus.dbg_isr !== '0 || bus.dbg_state[1:0] !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_eoi: valid %b isr %h st %0d, required 0 0 0",
                     bus.vec_valid, bus.dbg_isr, bus.dbg_state[1:0]);
        end
        cyc(1);
        check_sb_empty("single");
    endtask

    task automatic test_priority();
        do_reset();
        bus.prio_cfg[PW*3 +: PW] = 2'd1;
        bus.prio_cfg[PW*9 +: PW] = 2'd3;
        exp_q.push_back({8'd0, 8'd9});
        exp_q.push_back({8'd1, 8'd3});
        pulse_irq((32'h1 << 3) | (32'h1 << 9));
        cyc(1);
        tests_run++;
        if (bus.int_req !== 4'b0001 || bus.int_id[0 +: IW] !== 5'd9) begin
            tests_failed++;
            $display("FAIL prio_first: req %b id %0d, required 0001 id 9", bus.int_req, bus.int_id[0 +: IW]);
        end
        cyc(1);
        tests_run++;
        if (bus.int_req !== 4'b0011 || bus.int_id[IW +: IW] !== 5'd3) begin
            tests_failed++;
            $display("FAIL prio_second: req %b id1 %0d, required 0011 id 3", bus.int_req, bus.int_id[IW +: IW]);
        end
        cyc(1);
        check_sb_empty("prio");
    endtask

    task automatic test_mask();
        do_reset();
        bus.imr = ~(32'h1 << 7);
        pulse_irq(32'h1 << 7);
        cyc(3);
        tests_run++;
        if (bus.int_req !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mask_blocked: got %b, required 0000", bus.int_req);
        end
        exp_q.push_back({8'd0, 8'd7});
        bus.imr = '1;
        cyc(1);
        tests_run++;
        if (bus.int_req !== 4'b0001 || bus.int_id[0 +: IW] !== 5'd7) begin
            tests_failed++;
            $display("FAIL mask_release: req %b id %0d, required 0001 id 7", bus.int_req, bus.int_id[0 +: IW]);
        end
        cyc(1);
        check_sb_empty("mask");
    endtask

    task automatic test_saturation();
        logic [NCORE*IW-1:0] exp_ids;
        do_reset();
        for (int k = 0; k < NCORE; k++) exp_q.push_back({8'(k), 8'(10 + k)});
        pulse_irq(32'h3F << 10);
        cyc(4);
        exp_ids = {5'd13, 5'd12, 5'd11, 5'd10};
        tests_run++;
        if (bus.int_req !== 4'b1111 || bus.int_id !== exp_ids) begin
            tests_failed++;
            $display("FAIL sat_full: req %b ids %h, required 1111 %h", bus.int_req, bus.int_id, exp_ids);
        end
        // eoi in REQ is ignored; ack with eoi in REQ takes the ack only.
        eoi_core(0);
        bus.eoi[1] = 1'b1;
        ack_core(1);
        bus.eoi[1] = 1'b0;
        tests_run++;
        if (bus.dbg_state[1:0] !== 2'd1 || bus.dbg_state[3:2] !== 2'd2) begin
            tests_failed++;
            $display("FAIL sat_ignored: st0 %0d st1 %0d, required 1 2", bus.dbg_state[1:0], bus.dbg_state[3:2]);
        end
        ack_core(2);
        exp_q.push_back({8'd2, 8'd14});
        eoi_core(2);
        tests_run++;
        if (bus.int_req[2] !== 1'b0 || bus.dbg_state[5:4] !== 2'd0) begin
            tests_failed++;
            $display("FAIL sat_core2_idle: req2 %b st2 %0d, required 0 0", bus.int_req[2], bus.dbg_state[5:4]);
        end
        cyc(1);
        tests_run++;
        if (bus.int_req[2] !== 1'b1 || bus.int_id[2*IW +: IW] !== 5'd14) begin
            tests_failed++;
            $display("FAIL sat_redispatch: req2 %b id2 %0d, required 1 id 14", bus.int_req[2], bus.int_id[2*IW +: IW]);
        end
        cyc(1);
        check_sb_empty("sat");
    endtask

    task automatic test_tiebreak();
        logic [7:0] exp_order [4];
`ifdef MC_PIC_RR_EN
        exp_order = '{8'd2, 8'd4, 8'd2, 8'd4};
`else
        exp_order = '{8'd2, 8'd2, 8'd2, 8'd2};
`endif
        do_reset();
        bus.prio_cfg[PW*2 +: PW] = 2'd2;
        bus.prio_cfg[PW*4 +: PW] = 2'd2;
        for (int k = 0; k < NCORE; k++) exp_q.push_back({8'(k), 8'(20 + k)});
        pulse_irq(32'hF << 20);
        cyc(4);
        ack_core(0);
        for (int r = 0; r < 4; r++) begin
            pulse_irq((32'h1 << 2) | (32'h1 << 4));
            exp_q.push_back({8'd0, exp_order[r]});
            eoi_core(0);
            cyc(1);
            tests_run++;
            if (bus.int_req[0] !== 1'b1 || 8'(bus.int_id[0 +: IW]) !== exp_order[r]) begin
                tests_failed++;
                $display("FAIL tie_round%0d: req0 %b id %0d, required 1 id %0d",
                         r, bus.int_req[0], bus.int_id[0 +: IW], exp_order[r]);
            end
            ack_core(0);
        end
        cyc(1);
        check_sb_empty("tie");
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_q.push_back({8'd0, 8'd5});
        exp_q.push_back({8'd1, 8'd6});
        pulse_irq((32'h1 << 5) | (32'h1 << 6));
        cyc(2);
        ack_core(1);
        tests_run++;
        if (bus.vec_valid !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rmid_setup: valid %b, required 0010", bus.vec_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.int_req, bus.vec_valid} !== '0 || bus.int_id !== '0 || bus.dbg_isr !== '0) begin
            tests_failed++;
            $display("FAIL rmid_async: req %b valid %b id %h isr %h, required all 0",
                     bus.int_req, bus.vec_valid, bus.int_id, bus.dbg_isr);
        end
        tests_run++;
        if (bus.vector[32 +: 32] !== VBASE) begin
            tests_failed++;
            $display("FAIL rmid_vector: got %h, required %h", bus.vector[32 +: 32], VBASE);
        end
        exp_q.delete();
        cyc(1);
        reset = 1'b0;
        cyc(1);
        exp_q.push_back({8'd0, 8'd9});
        pulse_irq(32'h1 << 9);
        cyc(1);
        tests_run++;
        if (bus.int_req !== 4'b0001 || bus.int_id[0 +: IW] !== 5'd9) begin
            tests_failed++;
            $display("FAIL rmid_after: req %b id %0d, required 0001 id 9", bus.int_req, bus.int_id[0 +: IW]);
        end
        cyc(1);
        check_sb_empty("rmid");
    endtask

    initial begin
        bus.irq = '0; bus.imr = '1; bus.prio_cfg = '0; bus.int_ack = '0; bus.eoi = '0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_saturation();
        test_tiebreak();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mc_pic.md
MC_PIC -- requirements
Module: mc_pic

Interface
REQ-001 Parameter NSRC, default 32: number of interrupt sources, 2..64.
REQ-002 Parameter NCORE, default 4: number of served cores, 1..8.
REQ-003 Parameter PW, default 2: priority field width per source.
REQ-004 Parameter VBASE, default 32'hFFFF_FF00: vector base address.
REQ-005 Identifier width IW = clog2(NSRC).
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 irq  in  NSRC  level interrupt requests; bit i is source i.
REQ-009 imr  in  NSRC  enable mask; 1 = source may be dispatched.
REQ-010 prio_cfg  in  NSRC*PW  priority of source i in bits [PW*i +: PW]; larger value = more urgent.
REQ-011 int_req  out  NCORE  per-core interrupt request.
REQ-012 int_ack  in  NCORE  per-core acknowledge.
REQ-013 eoi  in  NCORE  per-core end-of-interrupt.
REQ-014 int_id  out  NCORE*IW  source id assigned to each core.
REQ-015 vector  out  NCORE*32  per-core vector, VBASE + id.
REQ-016 vec_valid  out  NCORE  vector of core k is valid.

Function
REQ-017 IRR update each edge: irr <= (irr & ~dispatch_clr) | irq.
  - A held-high irq re-pends its source after dispatch.
REQ-018 ISR: one bit per source.
  - Set on dispatch; cleared on eoi from the core holding that id.
  - A source SHALL never be in service on two cores at once.
REQ-019 Eligible source: irr & imr & ~isr.
REQ-020 Winner selection:
  - Highest prio_cfg value wins.
  - Ties resolve per REQ-032.
REQ-021 Dispatch, at most one per cycle:
  - Occurs when an eligible source exists and at least one core is IDLE.
  - The winner goes to the lowest-numbered IDLE core.
  - On the same edge: irr bit cleared, isr bit set, int_id[k] loaded.
REQ-022 Per-core FSM states:
  - IDLE -> REQ on dispatch.
  - REQ -> SERV on int_ack[k].
  - SERV -> IDLE on eoi[k].
REQ-023 int_req[k] SHALL be high exactly in REQ; vec_valid[k] SHALL be high exactly in SERV.
REQ-024 Latency: irq sampled at edge N -> irr set at N -> dispatch at N+1 -> int_req high after N+1.
REQ-025 vector[k] = VBASE + int_id[k]; registered on the REQ->SERV edge and held through SERV.
REQ-026 Ignored inputs:
  - int_ack outside REQ.
  - eoi outside SERV.
  - eoi and int_ack asserted together in REQ: ack taken, eoi ignored.
REQ-027 A core entering IDLE by eoi becomes dispatchable on the following cycle.
REQ-028 Mask or priority changes:
  - Affect only future dispatches.
  - Never revoke a request already in REQ or SERV.
  - Masked pending bits stay in irr.
REQ-029 Repeat requests: irq of a source in service sets irr; the source re-dispatches only after its isr bit clears.

Reset
REQ-030 On reset assertion, without waiting for a clock:
  - irr = 0, isr = 0.
  - All FSMs IDLE; int_req = 0, vec_valid = 0.
  - int_id = 0, vector = VBASE.
  - Round-robin pointer = 0.
REQ-031 Reset mid-operation SHALL abandon all in-flight requests; no eoi is required afterwards.

Configuration
REQ-032 Macro MC_PIC_RR_EN selects the tie-break among equal-highest priorities:
  - Defined: round-robin. Search starts at the id after the last dispatched id, wrapping NSRC-1 -> 0; the pointer updates on each dispatch.
  - Undefined: lowest index wins; no pointer state.

Verification
REQ-033 Single source: irq[5]=1 one cycle, imr all ones -> int_req[0] high 2 cycles later; ack -> vector[0]=FFFF_FF05, vec_valid[0]=1; eoi -> IDLE, isr[5]=0.
REQ-034 Priority: irq[3] prio 1 and irq[9] prio 3 raised together -> core0 gets 9, core1 gets 3 on the next cycle.
REQ-035 Mask: imr[7]=0, irq[7] pulsed -> no int_req; set imr[7]=1 -> int_req rises 1 cycle later with id 7.
REQ-036 Saturation, NCORE=4: six equal-prio sources pending -> four cores in REQ with distinct ids; after eoi on core2, the fifth id is dispatched to core2.
REQ-037 Tie-break, sources 2 and 4 at equal prio, pulsed repeatedly:
  - With MC_PIC_RR_EN: dispatch order alternates 2, 4, 2, 4.
  - Without it: 2 always wins first.
REQ-038 Reset while core1 is in SERV -> all outputs return to reset values immediately; a later irq dispatches to core0.
